// File: rtl/key_scan_pkg.sv
// Shared types, command codes and the key-matrix to command-code map for the
// keypad scanner.
package key_scan_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned CODE_W   = 5;
  localparam int unsigned IDX_W    = 2;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  localparam logic [CODE_W-1:0] KEY_IDLE  = 5'b11111;
  localparam logic [CODE_W-1:0] KEY_START = 5'b11100;
  localparam logic [CODE_W-1:0] KEY_RESET = 5'b11110;
  localparam logic [CODE_W-1:0] KEY_TIME  = 5'b11000;
  localparam logic [CODE_W-1:0] KEY_STAR  = 5'b01010;
  localparam logic [CODE_W-1:0] KEY_HASH  = 5'b01011;
  localparam logic [CODE_W-1:0] KEY_D     = 5'b01100;

  // Layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D, index = row*4 + col
  function automatic logic [CODE_W-1:0] key_map(input logic [IDX_W-1:0] row,
                                                 input logic [IDX_W-1:0] col);
    logic [CODE_W-1:0] code;
    case ({row, col})
      4'd0:    code = 5'b00001;
      4'd1:    code = 5'b00010;
      4'd2:    code = 5'b00011;
      4'd3:    code = KEY_START;
      4'd4:    code = 5'b00100;
      4'd5:    code = 5'b00101;
      4'd6:    code = 5'b00110;
      4'd7:    code = KEY_RESET;
      4'd8:    code = 5'b00111;
      4'd9:    code = 5'b01000;
      4'd10:   code = 5'b01001;
      4'd11:   code = KEY_TIME;
      4'd12:   code = KEY_STAR;
      4'd13:   code = 5'b00000;
      4'd14:   code = KEY_HASH;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider producing a one-cycle scan tick every SCAN_DIV cycles.
module scan_tick_gen #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q;
  logic             last_c;

  assign last_c = (cnt_q == CNT_W'(SCAN_DIV - 1));
  assign cnt_d  = last_c ? '0 : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= last_c;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/key_scan_ctrl.sv
// 4x4 keypad scanner: synchronizes and debounces the rows, and presents each
// confirmed key as a stable command code with a one-cycle valid pulse.
module key_scan_ctrl
  import key_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned DEBOUNCE_N = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_ROWS-1:0]           row_in,
  output logic [NUM_COLS-1:0]           col_out,
  output logic [CODE_W-1:0]             key_code,
  output logic                          key_valid,
  output logic                          key_held
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_N + 1);

  logic                tick;
  logic [NUM_ROWS-1:0] row_meta_q, row_sync_q;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    col_q, col_d;
  logic [IDX_W-1:0]    cand_row_q, cand_row_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_COLS-1:0] col_out_q, col_out_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                valid_q, valid_d;
  logic                held_q, held_d;

  logic                any_low_c;
  logic [IDX_W-1:0]    low_row_c;
  logic [CNT_W-1:0]    cnt_inc_c;
  logic [IDX_W-1:0]    col_next_c;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Two-flop synchronizer; pulled-up idle level is all ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
    end else begin
      row_meta_q <= row_in;
      row_sync_q <= row_meta_q;
    end
  end

  // Lowest active row index wins when several rows are low
  always_comb begin
    low_row_c = '0;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (!row_sync_q[r]) low_row_c = IDX_W'(r);
    end
  end

  assign any_low_c  = (row_sync_q != '1);
  assign cnt_inc_c  = (cnt_q == CNT_W'(DEBOUNCE_N)) ? cnt_q : cnt_q + CNT_W'(1);
  assign col_next_c = col_q + IDX_W'(1);

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    cand_row_d = cand_row_q;
    cnt_d      = cnt_q;
    code_d     = code_q;
    valid_d    = 1'b0;
    held_d     = held_q;

    if (tick) begin
      case (state_q)
        SCAN: begin
          if (any_low_c) begin
            cand_row_d = low_row_c;
            cnt_d      = CNT_W'(1);
            state_d    = DEBOUNCE;
          end else begin
            col_d = col_next_c;
          end
        end
        DEBOUNCE: begin
          if (any_low_c && (low_row_c == cand_row_q)) begin
            cnt_d = cnt_inc_c;
            if (cnt_inc_c == CNT_W'(DEBOUNCE_N)) begin
              code_d  = key_map(cand_row_q, col_q);
              valid_d = 1'b1;
              held_d  = 1'b1;
              state_d = HELD;
            end
          end else begin
            cnt_d   = '0;
            state_d = SCAN;
            col_d   = col_next_c;
          end
        end
        HELD: begin
          if (!any_low_c) begin
            cnt_d   = CNT_W'(1);
            state_d = RELEASE;
          end
        end
        RELEASE: begin
          if (any_low_c) begin
            state_d = HELD;
          end else begin
            cnt_d = cnt_inc_c;
            if (cnt_inc_c == CNT_W'(DEBOUNCE_N)) begin
              code_d  = KEY_IDLE;
              held_d  = 1'b0;
              state_d = SCAN;
              col_d   = col_next_c;
            end
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  assign col_out_d = ~(NUM_COLS'(1) << col_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SCAN;
      col_q      <= '0;
      cand_row_q <= '0;
      cnt_q      <= '0;
      col_out_q  <= 4'b1110;
      code_q     <= KEY_IDLE;
      valid_q    <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      cand_row_q <= cand_row_d;
      cnt_q      <= cnt_d;
      col_out_q  <= col_out_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      held_q     <= held_d;
    end
  end

  assign col_out   = col_out_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Bench for key_scan_ctrl: simulated key matrix, expected-code scoreboard
// derived from the keypad layout, directed and randomized press sequences.
module tb_key_scan_ctrl;

  localparam int unsigned DIV = 4;
  localparam int unsigned DBN = 3;
  localparam logic [4:0]  IDLE = 5'b11111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [4:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed;
  logic [4:0]  exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          viol = 0;
  int          cyc = 0;
  int          phase = 0;
  logic        prev_valid = 1'b0;

  key_scan_ctrl #(.SCAN_DIV(DIV), .DEBOUNCE_N(DBN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Passive matrix: a pressed key pulls its row low while its column is driven
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] ref_code(input int idx);
    string      layout = "123A456B789C*0#D";
    logic [7:0] ch;
    ch = layout[idx];
    if (ch >= 8'd48 && ch <= 8'd57) return {1'b0, 4'(ch - 8'd48)};
    case (ch)
      "A":     return 5'b11100;
      "B":     return 5'b11110;
      "C":     return 5'b11000;
      "*":     return 5'b01010;
      "#":     return 5'b01011;
      default: return 5'b01100;
    endcase
  endfunction

  // Scoreboard and protocol monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (key_valid) begin
        if (prev_valid) viol++;
        if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
        else chk("valid_code", key_code, exp_q.pop_front());
      end
      if (key_held && key_code == IDLE) viol++;
    end
    prev_valid = rst_n && key_valid;
  end

  task automatic wait_col_change(output int dt);
    logic [3:0] prev;
    prev = col_out;
    dt = 0;
    do begin
      @(negedge clk);
      dt++;
    end while (col_out == prev && dt < 20);
    if (col_out == prev) chk("col_timeout", 1, 0);
  endtask

  task automatic wait_col_to(input logic [3:0] target);
    int dt;
    for (int k = 0; k < 8; k++) begin
      wait_col_change(dt);
      if (col_out == target) return;
    end
    chk("col_target_timeout", col_out, target);
  endtask

  // Index of the first tick edge at or after edge e
  function automatic int next_tick(input int e);
    int f = e;
    while ((f % DIV) != phase) f++;
    return f;
  endfunction

  task automatic hold_and_release(input int idx, input int hold, input int gap);
    pressed[idx] = 1'b1;
    repeat (hold) @(negedge clk);
    chk("held_flag", key_held, 1);
    chk("held_code", key_code, ref_code(idx));
    pressed[idx] = 1'b0;
    repeat (gap) @(negedge clk);
    chk("released_code", key_code, IDLE);
    chk("released_flag", key_held, 0);
    chk("pending_valids", exp_q.size(), 0);
  endtask

  initial begin
    logic [3:0] rot_exp [5];
    int dt, t_edge, exp_edge, got_edge, bad;
    rot_exp = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};
    pressed = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_col", col_out, 4'b1110);
    chk("rst_code", key_code, IDLE);
    chk("rst_valid", key_valid, 0);
    chk("rst_held", key_held, 0);
    rst_n = 1'b1;

    // Idle rotation, one column step per scan tick
    for (int k = 0; k < 5; k++) begin
      wait_col_change(dt);
      if (k > 0) chk("rot_period", dt, DIV);
      chk("rot_col", col_out, rot_exp[k]);
    end
    chk("idle_code", key_code, IDLE);
    phase = cyc % DIV;

    // '7' press latency from the first low sample
    exp_q.push_back(ref_code(8));
    wait_col_to(4'b1110);
    t_edge = cyc;
    pressed[8] = 1'b1;
    exp_edge = next_tick(t_edge + 3) + (DBN - 1) * DIV;
    got_edge = -1;
    for (int k = 0; k < 60 && got_edge < 0; k++) begin
      @(negedge clk);
      if (key_valid) got_edge = cyc;
    end
    chk("press_latency", got_edge, exp_edge);
    repeat (60) @(negedge clk);
    chk("seven_held", key_held, 1);
    chk("seven_code", key_code, 5'b00111);

    // Release latency from the first clean sample
    while ((cyc % DIV) != phase) @(negedge clk);
    t_edge = cyc;
    pressed[8] = 1'b0;
    exp_edge = next_tick(t_edge + 3) + (DBN - 1) * DIV;
    got_edge = -1;
    for (int k = 0; k < 60 && got_edge < 0; k++) begin
      @(negedge clk);
      if (key_code == IDLE) got_edge = cyc;
    end
    chk("release_latency", got_edge, exp_edge);
    chk("release_held", key_held, 0);
    repeat (30) @(negedge clk);

    // One-sample glitch on 'A' then a clean press
    wait_col_to(4'b0111);
    pressed[3] = 1'b1;
    repeat (5) @(negedge clk);
    pressed[3] = 1'b0;
    repeat (30) @(negedge clk);
    chk("glitch_held", key_held, 0);
    chk("glitch_code", key_code, IDLE);
    exp_q.push_back(ref_code(3));
    hold_and_release(3, 80, 60);

    // Release bounce on 'B'
    exp_q.push_back(ref_code(7));
    pressed[7] = 1'b1;
    repeat (80) @(negedge clk);
    chk("b_held", key_held, 1);
    pressed[7] = 1'b0;
    repeat (DIV) @(negedge clk);
    pressed[7] = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (key_code != 5'b11110 || !key_held) bad++;
    end
    chk("rel_bounce_stable", bad, 0);
    pressed[7] = 1'b0;
    repeat (60) @(negedge clk);
    chk("b_pending", exp_q.size(), 0);
    chk("b_released", key_code, IDLE);

    // Overlap: hold '1', press '2', release '1'
    exp_q.push_back(ref_code(0));
    exp_q.push_back(ref_code(1));
    pressed[0] = 1'b1;
    repeat (60) @(negedge clk);
    chk("ovl_first_code", key_code, 5'b00001);
    pressed[1] = 1'b1;
    repeat (40) @(negedge clk);
    chk("ovl_still_first", key_code, 5'b00001);
    pressed[0] = 1'b0;
    repeat (100) @(negedge clk);
    chk("ovl_second_code", key_code, 5'b00010);
    pressed[1] = 1'b0;
    repeat (60) @(negedge clk);
    chk("ovl_pending", exp_q.size(), 0);

    // Lowest row wins, randomized keys and timing
    for (int t = 0; t < 20; t++) begin
      int idx, r, c, r2;
      idx = $urandom_range(0, 15);
      r = idx / 4;
      c = idx % 4;
      r2 = r;
      if ($urandom_range(0, 2) == 0) begin
        r2 = (r + 1 + $urandom_range(0, 2)) % 4;
        pressed[r2*4+c] = 1'b1;
      end
      exp_q.push_back(ref_code(((r2 < r) ? r2 : r) * 4 + c));
      pressed[idx] = 1'b1;
      repeat ($urandom_range(50, 120)) @(negedge clk);
      chk("rnd_held", key_held, 1);
      chk("rnd_code", key_code, ref_code(((r2 < r) ? r2 : r) * 4 + c));
      pressed = '0;
      repeat ($urandom_range(50, 90)) @(negedge clk);
      chk("rnd_idle", key_code, IDLE);
      chk("rnd_pending", exp_q.size(), 0);
    end

    // Asynchronous reset while 'C' is held
    exp_q.push_back(ref_code(11));
    pressed[11] = 1'b1;
    repeat (80) @(negedge clk);
    chk("c_held", key_held, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_code", key_code, IDLE);
    chk("mid_rst_held", key_held, 0);
    chk("mid_rst_valid", key_valid, 0);
    chk("mid_rst_col", col_out, 4'b1110);
    repeat (2) @(negedge clk);
    exp_q.push_back(ref_code(11));
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    chk("c_redetect_held", key_held, 1);
    chk("c_redetect_code", key_code, 5'b11000);
    pressed[11] = 1'b0;
    repeat (60) @(negedge clk);
    chk("c_pending", exp_q.size(), 0);

    chk("protocol_violations", viol, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/key_scan_ctrl.md
# key_scan_ctrl

Front-end controller for the keypad-driven calculator/timer datapath. It scans a 4x4 active-low key matrix, synchronizes and debounces the row inputs, and presents each confirmed key as a stable 5-bit command code on the datapath's key input, using the datapath's code space (all-ones = no key). It owns the column drive and decides when the datapath sees a key. Bouncing or overlapping presses never reach the arithmetic state machine.

## Interface
- SCAN_DIV, 1000: clock cycles per scan tick. Must be at least 4.
- DEBOUNCE_N, 8: consecutive consistent samples needed to confirm a press or a release. Range is 2..255.
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- row_in  in  4  matrix rows, active low, externally pulled up
- col_out  out  4  column drive, one-hot low
- key_code  out  5  command code to the datapath; 5'b11111 when idle
- key_valid  out  1  one-cycle pulse on a newly confirmed press
- key_held  out  1  high while a confirmed key is down

## Operation
- row_in passes through a 2-flop synchronizer before any use.
- Scan tick: a one-cycle pulse every SCAN_DIV cycles, from a free-running counter.
- Key index = row*4 + col. Layout is 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D.
- Digit keys map to {1'b0, BCD}, e.g. '7' -> 5'b00111 and '0' -> 5'b00000.
- Command keys map as follows:
  - A -> START 5'b11100
  - B -> RESET 5'b11110
  - C -> TIME 5'b11000
  - * -> 5'b01010
  - # -> 5'b01011
  - D -> 5'b01100
- State machine, sampling only on scan ticks:
  - SCAN: sample the synchronized rows for the current column. If no row is low, advance the column (0->1->2->3->0). If a row is low, latch the candidate {row, col}, set cnt=1, go to DEBOUNCE, and freeze the column.
  - DEBOUNCE: if the same row is low on the frozen column, cnt++. When cnt reaches DEBOUNCE_N, load key_code, pulse key_valid, go to HELD. Any other sample (no row, or a different row) clears cnt, returns to SCAN, and advances the column.
  - HELD: key_code and key_held stay stable. A sample with any row low keeps the state. A sample with no row low sets cnt=1 and goes to RELEASE.
  - RELEASE: a no-row sample does cnt++. Any low row returns to HELD with no new key_valid. When cnt reaches DEBOUNCE_N, key_code becomes 5'b11111, key_held drops, state goes to SCAN, and the column advances.
- Multiple rows low on one column: the lowest row index wins.
- Keys in other columns are invisible while the column is frozen.
- A second key pressed while one is held produces no new code. After the first key's release completes, the second key is detected on a later scan.

## Timing
- Reset values: col_out=4'b1110 (column 0), key_code=5'b11111, key_valid=0, key_held=0, state=SCAN, cnt=0, tick counter=0.
- Reset acts immediately and asynchronously, including mid-debounce or mid-hold. key_valid can never fire across reset.
- col_out updates the cycle after the tick that advances it. The rows then have SCAN_DIV-1 cycles, minus 2 synchronizer cycles, to settle before the next sample.
- key_code, key_held and key_valid are registered and change together, in the cycle after the confirming tick.
- Press latency from the first low sample: (DEBOUNCE_N-1)*SCAN_DIV + 1 cycles.
- Release latency from the first clean sample: the same.
- key_valid is exactly one cycle wide and fires once per confirmed press. key_code is never 5'b11111 while key_held=1.
- cnt saturates at DEBOUNCE_N and does not wrap. The tick counter wraps from SCAN_DIV-1 to 0.

## Structure
- Shared package key_scan_pkg holds:
  - the state enum (SCAN, DEBOUNCE, HELD, RELEASE)
  - code constants KEY_IDLE, KEY_START, KEY_RESET, KEY_TIME
  - the function key_map(row, col) returning 5 bits
- One sub-module, scan_tick_gen (parameter SCAN_DIV; ports clk, rst_n, tick). It is the free-running divider.
- The synchronizer, FSM, counter and output registers live in key_scan_ctrl.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_N=3.
- Reset, no keys: col_out rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110, one step per 4 cycles; key_code=5'b11111, key_valid never pulses.
- Clean press of '7' (row 2, col 0) held for 60 cycles: a single key_valid pulse with key_code=5'b00111, key_held=1. Release: key_code returns to 5'b11111 nine cycles after the first clean sample.
- Bounce: row 0 on col 3 low for 1 sample, then high, then stable low: no pulse for the glitch, then exactly one key_valid with key_code=5'b11100 (START).
- Release bounce: while 'B' is held, rows toggle high for 1 sample then low: no second key_valid, key_code stays 5'b11110 throughout.
- Overlap: hold '1', then press '2' and release '1': one key_valid for 5'b00001, then after the release completes, one key_valid for 5'b00010.
- Reset mid-hold: rst_n low while 'C' is held: outputs return immediately to 5'b11111/0/0 and col_out=1110. After reset releases with the key still down, the key is re-detected and yields one new key_valid with 5'b11000.
